// File: rtl/bc_msg_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bc_msg_router_pkg                                            |
// | Description : Shared message width and field layout for broadcast messages |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package bc_msg_router_pkg;

    localparam int c_msg_width  = 47;
    localparam int c_data_lsb   = 0;
    localparam int c_data_width = 32;
    localparam int c_mask_lsb   = 32;
    localparam int c_mask_width = 4;
    localparam int c_addr_lsb   = 36;
    localparam int c_addr_width = 11;

    typedef logic [c_msg_width-1:0] msg_t;

    function automatic msg_t pack_msg(input logic [c_data_width-1:0] data,
                                      input logic [c_mask_width-1:0] mask,
                                      input logic [c_addr_width-1:0] addr);
        return {addr, mask, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bc_msg_router_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bc_msg_router_if                                             |
// | Description : Core-side input handshake and broadcast output bus bundle    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface bc_msg_router_if
    import bc_msg_router_pkg::*;
#(
    parameter int CORE_COUNT    = 16,
    parameter int CORE_ID_WIDTH = 4,
    parameter int MSG_WIDTH     = c_msg_width
) ();

    logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg;
    logic [CORE_COUNT-1:0]           s_valid;
    logic [CORE_COUNT-1:0]           s_ready;
    logic [MSG_WIDTH-1:0]            m_msg;
    logic                            m_valid;
    logic [CORE_ID_WIDTH-1:0]        m_src;

    modport master (output s_msg, s_valid, input s_ready, m_msg, m_valid, m_src);
    modport slave  (input s_msg, s_valid, output s_ready, m_msg, m_valid, m_src);

endinterface
`default_nettype wire

// File: rtl/bc_msg_router_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bc_msg_fifo                                                  |
// | Description : Per-core synchronous FIFO with flush, head read from regs    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bc_msg_fifo
    import bc_msg_router_pkg::*;
#(
    parameter int WIDTH = c_msg_width,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_pw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_pw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bc_msg_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bc_msg_router                                                |
// | Description : Per-core FIFOs, round-robin arbiter and broadcast pipeline.  |
// |               Define BC_MSG_STATS_EN for per-core grant counters.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bc_msg_router
    import bc_msg_router_pkg::*;
#(
    parameter int CORE_COUNT    = 16,
    parameter int CORE_ID_WIDTH = 4,
    parameter int MSG_WIDTH     = c_msg_width,
    parameter int FIFO_DEPTH    = 4,
    parameter int PIPE_STAGES   = 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic [CORE_COUNT-1:0]    core_flush,
    input  wire logic [CORE_ID_WIDTH-1:0] stat_sel,
    output logic      [31:0]              stat_count,
    bc_msg_router_if.slave                bus
);

    logic [CORE_COUNT-1:0]    w_full;
    logic [CORE_COUNT-1:0]    w_empty;
    logic [CORE_COUNT-1:0]    w_req;
    logic [CORE_COUNT-1:0]    w_pop;
    logic [CORE_COUNT-1:0]    w_push;
    logic [MSG_WIDTH-1:0]     w_rd_data [CORE_COUNT];
    logic [CORE_ID_WIDTH-1:0] r_ptr;
    logic                     w_grant_valid;
    logic [CORE_ID_WIDTH-1:0] w_grant_idx;
    logic [MSG_WIDTH-1:0]     w_grant_msg;

    assign bus.s_ready = ~w_full & ~core_flush & {CORE_COUNT{~rst}};
    assign w_push      = bus.s_valid & bus.s_ready;
    assign w_req       = ~w_empty & ~core_flush;

    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_core
        bc_msg_fifo #(
            .WIDTH (MSG_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .i_flush     (core_flush[i]),
            .i_push      (w_push[i]),
            .i_push_data (bus.s_msg[i*MSG_WIDTH +: MSG_WIDTH]),
            .i_pop       (w_pop[i]),
            .o_rd_data   (w_rd_data[i]),
            .o_full      (w_full[i]),
            .o_empty     (w_empty[i])
        );
    end

    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= CORE_COUNT) idx = idx - CORE_COUNT;
            if (!w_grant_valid && w_req[idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = CORE_ID_WIDTH'(idx);
            end
        end
    end

    assign w_pop       = w_grant_valid ? (CORE_COUNT'(1) << w_grant_idx) : '0;
    assign w_grant_msg = w_rd_data[w_grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant_valid) begin
            r_ptr <= (w_grant_idx == CORE_ID_WIDTH'(CORE_COUNT - 1)) ? '0
                                                                      : w_grant_idx + CORE_ID_WIDTH'(1);
        end
    end

    logic [MSG_WIDTH-1:0]     r_pipe_msg   [PIPE_STAGES];
    logic [CORE_ID_WIDTH-1:0] r_pipe_src   [PIPE_STAGES];
    logic                     r_pipe_valid [PIPE_STAGES];

    // Payload only advances with a valid beat, so the output holds between messages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_pipe_msg[s]   <= '0;
                r_pipe_src[s]   <= '0;
                r_pipe_valid[s] <= 1'b0;
            end
        end else begin
            r_pipe_valid[0] <= w_grant_valid;
            if (w_grant_valid) begin
                r_pipe_msg[0] <= w_grant_msg;
                r_pipe_src[0] <= w_grant_idx;
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_pipe_valid[s] <= r_pipe_valid[s-1];
                if (r_pipe_valid[s-1]) begin
                    r_pipe_msg[s] <= r_pipe_msg[s-1];
                    r_pipe_src[s] <= r_pipe_src[s-1];
                end
            end
        end
    end

    assign bus.m_msg   = r_pipe_msg[PIPE_STAGES-1];
    assign bus.m_src   = r_pipe_src[PIPE_STAGES-1];
    assign bus.m_valid = r_pipe_valid[PIPE_STAGES-1];

`ifdef BC_MSG_STATS_EN
    logic [31:0] r_stat_cnt [CORE_COUNT];
    logic [31:0] r_stat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CORE_COUNT; i++) r_stat_cnt[i] <= '0;
            r_stat_count <= '0;
        end else begin
            if (w_grant_valid && (r_stat_cnt[w_grant_idx] != 32'hFFFF_FFFF)) begin
                r_stat_cnt[w_grant_idx] <= r_stat_cnt[w_grant_idx] + 32'd1;
            end
            r_stat_count <= r_stat_cnt[stat_sel];
        end
    end

    assign stat_count = r_stat_count;
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^stat_sel;
    assign stat_count        = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bc_msg_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bc_msg_router                                             |
// | Description : Directed self-checking bench for bc_msg_router               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bc_msg_router;
    import bc_msg_router_pkg::*;

    localparam int c_n   = 16;
    localparam int c_idw = 4;
    localparam int c_mw  = 47;

    logic             clk = 1'b0;
    logic             rst;
    logic [c_n-1:0]   core_flush;
    logic [c_idw-1:0] stat_sel;
    logic [31:0]      stat_count;

    bc_msg_router_if #(.CORE_COUNT(c_n), .CORE_ID_WIDTH(c_idw), .MSG_WIDTH(c_mw)) bus ();

    bc_msg_router #(
        .CORE_COUNT    (c_n),
        .CORE_ID_WIDTH (c_idw),
        .MSG_WIDTH     (c_mw),
        .FIFO_DEPTH    (4),
        .PIPE_STAGES   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_flush (core_flush),
        .stat_sel   (stat_sel),
        .stat_count (stat_count),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [c_idw-1:0] q_src [$];
    logic [c_mw-1:0]  q_msg [$];
    int               q_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.m_valid === 1'b1) begin
            q_src.push_back(bus.m_src);
            q_msg.push_back(bus.m_msg);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_mw-1:0] mk(input int c, input int n);
        return pack_msg(32'((c << 16) | n), 4'hA, 11'(c));
    endfunction

    function automatic logic [63:0] got_src(input int i);
        return (i < q_src.size()) ? 64'(q_src[i]) : 64'hDEAD;
    endfunction

    function automatic logic [63:0] got_msg(input int i);
        return (i < q_msg.size()) ? 64'(q_msg[i]) : 64'hDEAD;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.s_valid  = '0;
        core_flush   = '0;
        tick();
        rst = 1'b0;
        q_src.delete();
        q_msg.delete();
        q_cyc.delete();
    endtask

    task automatic idle(input int n);
        bus.s_valid = '0;
        repeat (n) tick();
    endtask

    task automatic set_msg(input int c, input logic [c_mw-1:0] m);
        bus.s_msg[c*c_mw +: c_mw] = m;
    endtask

    initial begin
        int              acc;
        int              first_block;
        int              n2;
        int              n7;
        logic [c_n-1:0]  rdy;

        rst         = 1'b1;
        core_flush  = '0;
        stat_sel    = '0;
        bus.s_valid = '0;
        bus.s_msg   = '0;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_msg", 64'(bus.m_msg), 64'd0);
        chk("rst_m_src", 64'(bus.m_src), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_stat", 64'(stat_count), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_s_ready", 64'(bus.s_ready), 64'hFFFF);

        // Single message, two-cycle latency, payload held afterwards
        set_msg(3, 47'h1234);
        bus.s_valid = 16'h0008;
        tick();
        bus.s_valid = '0;
        chk("t1_valid_t1", 64'(bus.m_valid), 64'd0);
        tick();
        chk("t1_valid_t2", 64'(bus.m_valid), 64'd1);
        chk("t1_msg", 64'(bus.m_msg), 64'h1234);
        chk("t1_src", 64'(bus.m_src), 64'd3);
        tick();
        chk("t1_valid_t3", 64'(bus.m_valid), 64'd0);
        chk("t1_msg_hold", 64'(bus.m_msg), 64'h1234);

        // All cores at once from ptr 0
        do_reset();
        for (int i = 0; i < c_n; i++) set_msg(i, mk(i, 0));
        bus.s_valid = '1;
        tick();
        idle(20);
        chk("t2_count", 64'(q_src.size()), 64'd16);
        for (int i = 0; i < c_n; i++) begin
            chk($sformatf("t2_src%0d", i), got_src(i), 64'(i));
            chk($sformatf("t2_msg%0d", i), got_msg(i), 64'(mk(i, 0)));
            if (i > 0 && i < q_cyc.size()) chk($sformatf("t2_cyc%0d", i), 64'(q_cyc[i] - q_cyc[0]), 64'(i));
        end

        // Core 5 streams 6 messages behind a few one-shot senders
        do_reset();
        for (int i = 0; i < 5; i++) set_msg(i, mk(i, 0));
        set_msg(5, mk(5, 0));
        bus.s_valid = 16'h003F;
        tick();
        acc         = 1;
        first_block = -1;
        for (int b = 0; b < 40 && acc < 6; b++) begin
            set_msg(5, mk(5, acc));
            bus.s_valid = 16'h0020;
            #1;
            rdy = bus.s_ready;
            if (!rdy[5] && first_block < 0) first_block = acc;
            tick();
            if (rdy[5]) acc++;
        end
        idle(20);
        chk("t3_accepts", 64'(acc), 64'd6);
        chk("t3_block_at", 64'(first_block), 64'd4);
        chk("t3_count", 64'(q_src.size()), 64'd11);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_src%0d", i), got_src(i), 64'(i));
            chk($sformatf("t3_msg%0d", i), got_msg(i), 64'(mk(i, 0)));
        end
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_c5_src%0d", k), got_src(5 + k), 64'd5);
            chk($sformatf("t3_c5_msg%0d", k), got_msg(5 + k), 64'(mk(5, k)));
        end

        // Cores 2 and 7 continuously valid: strict alternation across the wrap
        do_reset();
        n2 = 0;
        n7 = 0;
        for (int k = 0; k < 12; k++) begin
            set_msg(2, mk(2, n2));
            set_msg(7, mk(7, n7));
            bus.s_valid = 16'h0084;
            #1;
            rdy = bus.s_ready;
            tick();
            if (rdy[2]) n2++;
            if (rdy[7]) n7++;
        end
        idle(20);
        chk("t4_n2", 64'(n2), 64'd9);
        chk("t4_n7", 64'(n7), 64'd9);
        chk("t4_count", 64'(q_src.size()), 64'd18);
        for (int j = 0; j < 18; j++) begin
            chk($sformatf("t4_src%0d", j), got_src(j), (j % 2 == 0) ? 64'd2 : 64'd7);
            chk($sformatf("t4_msg%0d", j), got_msg(j), 64'(mk((j % 2 == 0) ? 2 : 7, j / 2)));
        end

        // Flush core 4 while it holds three queued messages
        do_reset();
        for (int i = 0; i < 5; i++) set_msg(i, mk(i, 0));
        bus.s_valid = 16'h001F;
        tick();
        set_msg(4, mk(4, 1));
        bus.s_valid = 16'h0010;
        tick();
        set_msg(4, mk(4, 2));
        tick();
        bus.s_valid = '0;
        tick();
        core_flush = 16'h0010;
        set_msg(4, mk(4, 7));
        bus.s_valid = 16'h0010;
        #1;
        chk("t5_ready_flush", 64'(bus.s_ready[4]), 64'd0);
        tick();
        core_flush = '0;
        idle(6);
        set_msg(4, mk(4, 9));
        bus.s_valid = 16'h0010;
        tick();
        idle(6);
        chk("t5_count", 64'(q_src.size()), 64'd5);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5_src%0d", i), got_src(i), 64'(i));
            chk($sformatf("t5_msg%0d", i), got_msg(i), 64'(mk(i, 0)));
        end
        chk("t5_after_src", got_src(4), 64'd4);
        chk("t5_after_msg", got_msg(4), 64'(mk(4, 9)));

        // Counters, then reset in the middle of a stream
        do_reset();
        stat_sel = 4'd1;
        for (int k = 0; k < 10; k++) begin
            set_msg(1, mk(1, k));
            bus.s_valid = 16'h0002;
            tick();
        end
        idle(4);
`ifdef BC_MSG_STATS_EN
        chk("t6_stat_core1", 64'(stat_count), 64'd10);
`else
        chk("t6_stat_off", 64'(stat_count), 64'd0);
`endif
        stat_sel = 4'd0;
        tick();
        chk("t6_stat_core0", 64'(stat_count), 64'd0);
        stat_sel = 4'd1;
        for (int k = 0; k < 3; k++) begin
            set_msg(1, mk(1, 20 + k));
            bus.s_valid = 16'h0002;
            tick();
        end
        chk("t6_midstream_valid", 64'(bus.m_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("t6_rst_valid", 64'(bus.m_valid), 64'd0);
        chk("t6_rst_stat", 64'(stat_count), 64'd0);
        chk("t6_rst_ready", 64'(bus.s_ready), 64'd0);
        rst         = 1'b0;
        bus.s_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6_post_rst_valid%0d", k), 64'(bus.m_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
